// File: rtl/alu_rf_sequencer.sv
// alu_rf_sequencer: multi-cycle controller that iterates rd = src OP (rt | imm)
// through an external register file and ALU, one READ/WRITE pair per iteration.
// Optional build macro SEQ_OVF_STOP_EN: an ALU overflow in READ ends the command
// without writing that iteration's result.
module alu_rf_sequencer #(
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned WORD_W  = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [4:0]         cmd_rs,
    input  logic [4:0]         cmd_rt,
    input  logic [4:0]         cmd_rd,
    input  logic               cmd_use_imm,
    input  logic [15:0]        cmd_imm,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic               cmd_abort,
    output logic [4:0]         rf_rsel1,
    output logic [4:0]         rf_rsel2,
    input  logic [WORD_W-1:0]  rf_rdat1,
    input  logic [WORD_W-1:0]  rf_rdat2,
    output logic [4:0]         rf_wsel,
    output logic [WORD_W-1:0]  rf_wdat,
    output logic               rf_WEN,
    output logic [WORD_W-1:0]  alu_portA,
    output logic [WORD_W-1:0]  alu_portB,
    output logic [3:0]         alu_op,
    input  logic [WORD_W-1:0]  alu_portOut,
    input  logic               alu_neg,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               busy,
    output logic               done,
    output logic [WORD_W-1:0]  result,
    output logic [3:0]         flags
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned IMM_W = 16;

`ifdef SEQ_OVF_STOP_EN
    localparam bit OVF_STOP = 1'b1;
`else
    localparam bit OVF_STOP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t             state;
    logic [OP_W-1:0]    op_q;
    logic [REG_W-1:0]   rt_q;
    logic [REG_W-1:0]   rd_q;
    logic               use_imm_q;
    logic [IMM_W-1:0]   imm_q;
    logic [COUNT_W-1:0] remaining;
    logic               neg_q;
    logic               zero_q;
    logic               ovf_q;
    logic               abort_q;

    // Overflow stop only exists when the build macro is defined.
    logic ovf_stop;
    assign ovf_stop = OVF_STOP & alu_overflow;

    assign alu_op = op_q;
    assign flags  = {abort_q, ovf_q, zero_q, neg_q};

    // ALU operands follow the register file read data only while in READ.
    always_comb begin
        alu_portA = '0;
        alu_portB = '0;
        if (state == S_READ) begin
            alu_portA = rf_rdat1;
            alu_portB = use_imm_q ? WORD_W'(imm_q) : rf_rdat2;
        end
    end

    // Sequencer FSM with registered handshake, status and register-file controls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            remaining <= '0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            abort_q   <= 1'b0;
            result    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_WEN    <= 1'b0;
            rf_rsel1  <= '0;
            rf_rsel2  <= '0;
            rf_wsel   <= '0;
            rf_wdat   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        rt_q      <= cmd_rt;
                        rd_q      <= cmd_rd;
                        use_imm_q <= cmd_use_imm;
                        imm_q     <= cmd_imm;
                        remaining <= (cmd_count == '0) ? COUNT_W'(1) : cmd_count;
                        ovf_q     <= 1'b0;
                        abort_q   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        rf_rsel1  <= cmd_rs;
                        rf_rsel2  <= cmd_rt;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    rf_rsel1 <= '0;
                    rf_rsel2 <= '0;
                    if (cmd_abort) begin
                        abort_q <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        result <= alu_portOut;
                        neg_q  <= alu_neg;
                        zero_q <= alu_zero;
                        ovf_q  <= ovf_q | alu_overflow;
                        if (ovf_stop) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rf_WEN  <= (rd_q != '0);
                            rf_wsel <= rd_q;
                            rf_wdat <= alu_portOut;
                            state   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    rf_WEN    <= 1'b0;
                    rf_wsel   <= '0;
                    rf_wdat   <= '0;
                    remaining <= remaining - COUNT_W'(1);
                    if (remaining == COUNT_W'(1) || cmd_abort) begin
                        abort_q <= abort_q | cmd_abort;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        // Later iterations accumulate into rd.
                        rf_rsel1 <= rd_q;
                        rf_rsel2 <= rt_q;
                        state    <= S_READ;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
